imem_loader: RTL and testbench

- Boot/configuration sequencer for the pipelined core.
- Receives a byte stream from the chip pins (8-bit data plus valid/ready handshake) and assembles it little-endian into 32-bit instruction words.
- Writes those words into the instruction memory and holds the core in reset for the whole load.
- After the last word it waits a programmable number of cycles, then releases the core. The core then starts fetching from word address 0.

---
 rtl/imem_loader_pkg.sv | 27 ++
 rtl/imem_loader_byte_assembler.sv | 41 ++++
 rtl/imem_loader.sv | 111 +++++++++++
 tb/tb_imem_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and word-format constants for the boot loader.
// Rev 1.0
`default_nettype none

package imem_loader_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int INSTR_WIDTH    = 32;
   localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_HEADER  = 3'd1;
   localparam logic [2:0] ST_LOAD    = 3'd2;
   localparam logic [2:0] ST_RELEASE = 3'd3;
   localparam logic [2:0] ST_RUN     = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      HEADER  = ST_HEADER,
      LOAD    = ST_LOAD,
      RELEASE = ST_RELEASE,
      RUN     = ST_RUN
   } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_assembler.sv
// imem_loader_byte_assembler: packs accepted bytes little-endian into instruction words.
// Rev 1.0
`default_nettype none

module imem_loader_byte_assembler
   import imem_loader_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_clear,
   input  logic                   i_accept,
   input  logic [7:0]             i_byte,
   output logic                   o_word_done,
   output logic [INSTR_WIDTH-1:0] o_word
);

   localparam int SHIFT_W = INSTR_WIDTH - 8;

   logic [SHIFT_W-1:0]    r_shift;
   logic [BYTE_CNT_W-1:0] r_cnt;

   // The final byte is merged combinationally so the word is ready on the accepting edge.
   assign o_word_done = i_accept && (r_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
   assign o_word      = {i_byte, r_shift};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (i_clear) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (i_accept) begin
         r_shift <= {i_byte, r_shift[SHIFT_W-1:8]};
         r_cnt   <= r_cnt + BYTE_CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed program into instruction memory, then releases the core.
// Rev 1.0
`default_nettype none

module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH     = 8,
   parameter int RELEASE_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_load_req,
   input  logic [7:0]             i_byte_in,
   input  logic                   i_byte_valid,
   output logic                   o_byte_ready,
   output logic                   o_imem_we,
   output logic [ADDR_WIDTH-1:0]  o_imem_waddr,
   output logic [INSTR_WIDTH-1:0] o_imem_wdata,
   output logic                   o_core_rst_n,
   output logic                   o_loading,
   output logic [ADDR_WIDTH:0]    o_words_loaded
);

   state_t                  r_state;
   state_t                  w_next_state;
   logic [7:0]              r_len;
   logic [ADDR_WIDTH-1:0]   r_word_cnt;
   logic [ADDR_WIDTH:0]     r_words_loaded;
   logic [3:0]              r_rel_cnt;
   logic                    r_we;
   logic [ADDR_WIDTH-1:0]   r_waddr;
   logic [INSTR_WIDTH-1:0]  r_wdata;
   logic                    r_core_rst_n;

   logic                    w_hdr_accept;
   logic                    w_load_accept;
   logic                    w_word_done;
   logic [INSTR_WIDTH-1:0]  w_word;
   logic                    w_last_word;

   assign o_byte_ready   = (r_state == HEADER) || (r_state == LOAD);
   assign o_loading      = o_byte_ready || (r_state == RELEASE);
   assign o_imem_we      = r_we;
   assign o_imem_waddr   = r_waddr;
   assign o_imem_wdata   = r_wdata;
   assign o_core_rst_n   = r_core_rst_n;
   assign o_words_loaded = r_words_loaded;

   assign w_hdr_accept  = i_byte_valid && (r_state == HEADER);
   assign w_load_accept = i_byte_valid && (r_state == LOAD);
   // Header byte L means L+1 words, so the last word has index L.
   assign w_last_word   = w_word_done && (r_word_cnt == ADDR_WIDTH'(r_len));

   imem_loader_byte_assembler u_asm (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clear     (r_state != LOAD),
      .i_accept    (w_load_accept),
      .i_byte      (i_byte_in),
      .o_word_done (w_word_done),
      .o_word      (w_word)
   );

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (i_load_req) w_next_state = HEADER;
         HEADER:  if (w_hdr_accept) w_next_state = LOAD;
         LOAD:    if (w_last_word) w_next_state = RELEASE;
         RELEASE: if (r_rel_cnt == 4'(RELEASE_CYCLES)) w_next_state = RUN;
         RUN:     if (i_load_req) w_next_state = HEADER;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_len          <= '0;
         r_word_cnt     <= '0;
         r_words_loaded <= '0;
         r_rel_cnt      <= '0;
         r_we           <= 1'b0;
         r_waddr        <= '0;
         r_wdata        <= '0;
         r_core_rst_n   <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_core_rst_n <= (w_next_state == RUN);
         r_we         <= 1'b0;
         if (w_hdr_accept) begin
            r_len          <= i_byte_in;
            r_word_cnt     <= '0;
            r_words_loaded <= '0;
         end
         if (w_word_done) begin
            r_we           <= 1'b1;
            r_waddr        <= r_word_cnt;
            r_wdata        <= w_word;
            r_word_cnt     <= r_word_cnt + ADDR_WIDTH'(1);
            r_words_loaded <= r_words_loaded + (ADDR_WIDTH+1)'(1);
         end
         if (r_state == RELEASE) r_rel_cnt <= r_rel_cnt + 4'd1;
         else                    r_rel_cnt <= '0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for the instruction-memory boot loader.
// Rev 1.0
`default_nettype none

module tb_imem_loader;

   localparam int AW = 8;
   localparam int RC = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_load_req;
   logic [7:0]    i_byte_in;
   logic          i_byte_valid;
   logic          o_byte_ready;
   logic          o_imem_we;
   logic [AW-1:0] o_imem_waddr;
   logic [31:0]   o_imem_wdata;
   logic          o_core_rst_n;
   logic          o_loading;
   logic [AW:0]   o_words_loaded;

   imem_loader #(.ADDR_WIDTH(AW), .RELEASE_CYCLES(RC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_load_req     (i_load_req),
      .i_byte_in      (i_byte_in),
      .i_byte_valid   (i_byte_valid),
      .o_byte_ready   (o_byte_ready),
      .o_imem_we      (o_imem_we),
      .o_imem_waddr   (o_imem_waddr),
      .o_imem_wdata   (o_imem_wdata),
      .o_core_rst_n   (o_core_rst_n),
      .o_loading      (o_loading),
      .o_words_loaded (o_words_loaded)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          addr;
      logic [31:0] data;
      int          cyc;
      int          wl;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] payload[$];
   int         n_checks = 0;
   int         n_pass   = 0;

   function automatic void check(input string name, input longint act, input longint expv);
      n_checks++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
   endfunction

   // Scoreboard monitor: every write must match the oldest expected word.
   always @(negedge clk) begin
      if (rst_n && o_imem_we) begin
         if (exp_q.size() == 0) begin
            check("unexpected imem write", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("imem_waddr", o_imem_waddr, e.addr);
            check("imem_wdata", o_imem_wdata, e.data);
            check("write cycle", cyc, e.cyc);
            check("words_loaded at write", o_words_loaded, e.wl);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, output int acc);
      int waited;
      waited       = 0;
      acc          = -1;
      i_byte_valid = 1'b1;
      i_byte_in    = b;
      while (acc < 0 && waited <= 100) begin
         @(negedge clk);
         if (o_byte_ready) acc = cyc + 1;
         else waited++;
      end
      if (acc < 0) check("byte_ready timeout", 0, 1);
      tick();
      i_byte_valid = 1'b0;
      i_byte_in    = 8'($urandom);
   endtask

   // Sends header plus payload; stop_at >= 0 aborts after that many payload bytes.
   task automatic run_load(input bit throttle, input int stop_at);
      int          nw, acc, last_acc, rise;
      logic [31:0] word;
      nw         = payload.size() / 4;
      i_load_req = 1'b1;
      send_byte(8'(nw - 1), acc);
      i_load_req = 1'b0;
      check("words_loaded cleared by header", o_words_loaded, 0);
      last_acc = 0;
      for (int i = 0; i < payload.size(); i++) begin
         if (stop_at >= 0 && i == stop_at) return;
         if (throttle) repeat ($urandom_range(0, 2)) tick();
         send_byte(payload[i], acc);
         if (i % 4 == 3) begin
            word = 32'(payload[i-3]) + (32'(payload[i-2]) << 8)
                 + (32'(payload[i-1]) << 16) + (32'(payload[i]) << 24);
            exp_q.push_back('{addr: (i / 4) % 256, data: word, cyc: acc, wl: i / 4 + 1});
            last_acc = acc;
         end
      end
      check("byte_ready low after final byte", o_byte_ready, 0);
      check("loading during release", o_loading, 1);
      rise = -1;
      for (int k = 0; k < 40 && rise < 0; k++) begin
         @(negedge clk);
         if (o_core_rst_n) rise = cyc;
      end
      check("core_rst_n rise cycle", rise, last_acc + RC + 1);
      check("words_loaded after load", o_words_loaded, nw);
      check("loading low in RUN", o_loading, 0);
      check("scoreboard drained", exp_q.size(), 0);
   endtask

   task automatic fill_random(input int nbytes);
      payload.delete();
      for (int i = 0; i < nbytes; i++) payload.push_back(8'($urandom));
   endtask

   initial begin
      rst_n        = 1'b0;
      i_load_req   = 1'b0;
      i_byte_valid = 1'b0;
      i_byte_in    = 8'h00;
      #1;
      check("reset core_rst_n", o_core_rst_n, 0);
      check("reset byte_ready", o_byte_ready, 0);
      check("reset imem_we", o_imem_we, 0);
      check("reset imem_waddr", o_imem_waddr, 0);
      check("reset imem_wdata", o_imem_wdata, 0);
      check("reset loading", o_loading, 0);
      check("reset words_loaded", o_words_loaded, 0);
      repeat (3) tick();
      rst_n = 1'b1;

      // Idle: nothing moves without load_req; random garbage on the byte lane.
      for (int i = 0; i < 20; i++) begin
         i_byte_valid = 1'($urandom);
         i_byte_in    = 8'($urandom);
         tick();
         check("idle core_rst_n", o_core_rst_n, 0);
         check("idle byte_ready", o_byte_ready, 0);
      end
      i_byte_valid = 1'b0;

      // Single word 0x00100513.
      payload = '{8'h13, 8'h05, 8'h10, 8'h00};
      run_load(1'b0, -1);

      // Throttled three-word load.
      fill_random(12);
      run_load(1'b1, -1);

      // Maximum length: 256 words, addresses wrap back to 0 afterwards.
      fill_random(1024);
      run_load(1'b0, -1);

      // Reload from RUN.
      i_load_req = 1'b1;
      tick();
      check("reload core_rst_n low", o_core_rst_n, 0);
      check("reload byte_ready", o_byte_ready, 1);
      check("reload words_loaded before header", o_words_loaded, 256);
      fill_random(8);
      run_load(1'b0, -1);

      // Reset after byte 2 of word 1.
      fill_random(16);
      run_load(1'b1, 7);
      rst_n = 1'b0;
      #1;
      check("midload reset core_rst_n", o_core_rst_n, 0);
      check("midload reset loading", o_loading, 0);
      check("midload reset byte_ready", o_byte_ready, 0);
      check("midload reset words_loaded", o_words_loaded, 0);
      check("midload scoreboard drained", exp_q.size(), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check("post reset idle loading", o_loading, 0);

      fill_random(8);
      run_load(1'b1, -1);

      repeat (5) tick();
      check("final scoreboard empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
